// File: rtl/sram_controller_pkg.sv
// Shared constants and FSM encoding for the 32-bit pipeline to 16-bit async SRAM bridge.
package sram_controller_pkg;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned ADDR_W_DEF      = 32;
  localparam int unsigned SRAM_DATA_W_DEF = 16;
  localparam int unsigned SRAM_ADDR_W_DEF = 18;
  localparam int unsigned BASE_ADDR_DEF   = 1024;
  localparam int unsigned WAIT_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Width of the per-phase wait counter; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/sram_controller_if.sv
// Pipeline request/response and SRAM bus signals of the SRAM bridge.
interface sram_controller_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SRAM_DATA_W = 16,
  parameter int unsigned SRAM_ADDR_W = 18
);
  logic                   wr_en;
  logic                   rd_en;
  logic [ADDR_W-1:0]      address;
  logic [DATA_W-1:0]      write_data;
  logic [DATA_W-1:0]      read_data;
  logic                   ready;
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic                   sram_we_n;
  logic [SRAM_DATA_W-1:0] sram_dq_out;
  logic                   sram_dq_oe;
  logic [SRAM_DATA_W-1:0] sram_dq_in;

  // The master side is the pipeline together with the board-level SRAM.
  modport master (
    output wr_en, rd_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport slave (
    input  wr_en, rd_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter timing one halfword phase; saturates at zero.
module sram_wait_counter #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/sram_controller.sv
// Splits a 32-bit load/store into two timed halfword accesses on an async SRAM,
// holding ready low so the pipeline freezes until the word is complete.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned SRAM_DATA_W = DATA_W / 2,
  parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int unsigned BASE_ADDR   = BASE_ADDR_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input logic            clk,
  input logic            rst,
  sram_controller_if.slave bus
);
  localparam int unsigned      CNT_W    = cnt_w(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single-cycle phase the only cycle is also the recovery cycle.
  localparam logic             ONE_CYC  = (WAIT_CYCLES == 1);

  state_e                 state_q;
  logic                   wr_q;
  logic [SRAM_DATA_W-1:0] hi_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic                   we_n_q;
  logic                   oe_q;
  logic [SRAM_DATA_W-1:0] dout_q;

  logic             req;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;

  function automatic logic [SRAM_ADDR_W-1:0] lo_hw(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] word;
    word = {a[ADDR_W-1:2], 2'b00} - ADDR_W'(BASE_ADDR);
    return word[SRAM_ADDR_W:1];
  endfunction

  assign req = bus.wr_en | bus.rd_en;

  always_comb begin
    cnt_load = (state_q == ST_IDLE && req) || (state_q == ST_LOW && cnt_zero);
    cnt_dec  = (state_q == ST_LOW) || (state_q == ST_HIGH);
  end

  sram_wait_counter #(.CNT_W(CNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (CNT_LOAD),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // Bus outputs are computed one cycle ahead so they are registered in the
  // cycle they describe; we_n rises for the last cycle of a phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      we_n_q  <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (req) begin
          state_q <= ST_LOW;
          wr_q    <= bus.wr_en;
          hi_q    <= bus.write_data[DATA_W-1:SRAM_DATA_W];
          addr_q  <= lo_hw(bus.address);
          we_n_q  <= !(bus.wr_en && !ONE_CYC);
          oe_q    <= bus.wr_en;
          dout_q  <= bus.write_data[SRAM_DATA_W-1:0];
        end
        ST_LOW: if (cnt_zero) begin
          if (!wr_q) rdata_q[SRAM_DATA_W-1:0] <= bus.sram_dq_in;
          state_q <= ST_HIGH;
          addr_q  <= addr_q + 1'b1;
          we_n_q  <= !(wr_q && !ONE_CYC);
          dout_q  <= hi_q;
        end else begin
          we_n_q  <= !wr_q || (cnt == CNT_ONE);
        end
        ST_HIGH: if (cnt_zero) begin
          if (!wr_q) rdata_q[DATA_W-1:SRAM_DATA_W] <= bus.sram_dq_in;
          state_q <= ST_DONE;
          we_n_q  <= 1'b1;
          oe_q    <= 1'b0;
        end else begin
          we_n_q  <= !wr_q || (cnt == CNT_ONE);
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready       = (state_q == ST_IDLE && !req) || (state_q == ST_DONE);
  assign bus.read_data   = rdata_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_we_n   = we_n_q;
  assign bus.sram_dq_oe  = oe_q;
  assign bus.sram_dq_out = dout_q;
endmodule
